// File: rtl/multicycle_cpu.sv
// Multi-cycle 8-bit-ISA core (ADD/LW/SW/BR) with valid-qualified fetch and display port.
// Define MCPU_HALT_EN to turn branch-to-self (0xFF) into a terminal HALT state.
module multicycle_cpu #(
    parameter int DATA_W     = 8,
    parameter int PC_W       = 8,
    parameter int DMEM_DEPTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   instr_addr,
    output logic              instr_req,
    input  logic [7:0]        instr_data,
    input  logic              instr_valid,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              halted,
    output logic [2:0]        state_dbg
);
    localparam int AW = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_BR  = 2'b11;

    state_t            state, state_next;
    logic [PC_W-1:0]   pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] a, b, alu_out, mdr;
    logic [DATA_W-1:0] gpr [4];
    logic [DATA_W-1:0] mem [DMEM_DEPTH];

    logic [1:0]        op, rs, rt, rd, wb_dst;
    logic [DATA_W-1:0] imm_d, wb_val;
    logic [PC_W-1:0]   imm_p;
    logic [AW-1:0]     addr;
    logic              halt_br;
    logic              addr_unused;

    assign op     = ir[7:6];
    assign rs     = ir[5:4];
    assign rt     = ir[3:2];
    assign rd     = ir[1:0];
    assign imm_d  = {{(DATA_W-2){ir[1]}}, ir[1:0]};
    assign imm_p  = {{(PC_W-2){ir[1]}}, ir[1:0]};
    assign addr   = alu_out[AW-1:0];
    assign addr_unused = ^alu_out[DATA_W-1:AW];
    assign wb_val = (op == OP_LW) ? mdr : alu_out;
    assign wb_dst = (op == OP_LW) ? rt : rd;

`ifdef MCPU_HALT_EN
    assign halt_br = (ir == 8'hFF);
    assign halted  = (state == S_HALT);
`else
    assign halt_br = 1'b0;
    assign halted  = 1'b0;
`endif

    assign instr_addr = pc;
    assign instr_req  = (state == S_FETCH);
    assign state_dbg  = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:  if (instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (op == OP_BR)       state_next = halt_br ? S_HALT : S_FETCH;
                else if (op == OP_ADD) state_next = S_WB;
                else                   state_next = S_MEM;
            end
            S_MEM:    state_next = (op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // Data memory resets to an identity pattern so loads are observable without a preload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) gpr[i] <= '0;
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) mem[i] <= DATA_W'(i);
        end else begin
            disp_valid <= (state == S_WB);
            case (state)
                S_FETCH:  if (instr_valid) ir <= instr_data;
                S_DECODE: begin
                    a <= gpr[rs];
                    b <= gpr[rt];
                end
                S_EXEC: begin
                    alu_out <= a + ((op == OP_ADD) ? b : imm_d);
                    if (op == OP_BR) begin
                        if (!halt_br) pc <= pc + PC_W'(1) + imm_p;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                S_MEM: begin
                    if (op == OP_LW)      mdr <= mem[addr];
                    else if (op == OP_SW) mem[addr] <= b;
                end
                S_WB: begin
                    gpr[wb_dst] <= wb_val;
                    disp_data   <= wb_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: display writes are queued with expected value and cycle.
module tb_multicycle_cpu;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] instr_addr;
    logic       instr_req;
    logic [7:0] instr_data = 8'hC0;
    logic       instr_valid = 1'b1;
    logic [7:0] disp_data;
    logic       disp_valid;
    logic       halted;
    logic [2:0] state_dbg;

    multicycle_cpu #(.DATA_W(8), .PC_W(8), .DMEM_DEPTH(32)) dut (
        .clock(clock), .reset(reset),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_valid(instr_valid),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .halted(halted), .state_dbg(state_dbg)
    );

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] imem [256];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial forever #5 clock = ~clock;

    // cyc = number of rising edges since reset release
    initial forever begin
        @(posedge clock);
        if (reset) cyc = 0;
        else       cyc++;
    end

    // Instruction memory model, refreshed shortly after every edge
    initial forever begin
        @(posedge clock);
        #2;
        instr_data = imem[instr_addr];
    end

    initial forever begin
        @(negedge clock);
        if (!reset && disp_valid) begin
            if (sb.size() == 0) begin
                check_eq("disp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("disp_data", disp_data, e.data);
                check_eq("disp_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int req_count;
        int mem_ok;
        for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
        imem[0] = 8'h45;
        imem[1] = 8'h16;
        imem[2] = 8'h8B;
        imem[3] = 8'h4F;
        imem[4] = 8'hC1;
        imem[6] = 8'hFF;

        step(2);
        check_eq("rst_state", state_dbg, 0);
        check_eq("rst_req", instr_req, 1);
        check_eq("rst_pc", instr_addr, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_disp_valid", disp_valid, 0);
        check_eq("rst_disp_data", disp_data, 0);

        // Start the LW, then abort it in WB before the register write lands
        reset = 1'b0;
        step(4);
        check_eq("pre_abort_state", state_dbg, 4);
        reset = 1'b1;
        #1;
        check_eq("abort_state", state_dbg, 0);
        check_eq("abort_req", instr_req, 1);
        check_eq("abort_pc", instr_addr, 0);
        check_eq("abort_r1", dut.gpr[1], 0);
        mem_ok = 0;
        for (int i = 0; i < 32; i++) if (dut.mem[i] == 8'(i)) mem_ok++;
        check_eq("abort_mem_identity", mem_ok, 32);
        step(2);

        sb.push_back('{8'h01, 5});
        sb.push_back('{8'h02, 9});
        sb.push_back('{8'h02, 18});
        reset = 1'b0;
        step(5);
        check_eq("lw_r1", dut.gpr[1], 8'h01);
        step(4);
        check_eq("add_r2", dut.gpr[2], 8'h02);
        step(4);
        check_eq("sw_mem31", dut.mem[31], 8'h02);
        check_eq("sw_pc", instr_addr, 3);
        step(5);
        check_eq("lw_r3", dut.gpr[3], 8'h02);
        step(3);
        check_eq("br_fwd_pc", instr_addr, 6);
        check_eq("br_fwd_state", state_dbg, 0);

`ifdef MCPU_HALT_EN
        step(5);
        check_eq("halt_halted", halted, 1);
        check_eq("halt_state", state_dbg, 5);
        check_eq("halt_req", instr_req, 0);
        check_eq("halt_pc", instr_addr, 6);
        step(10);
        check_eq("halt_sticky", state_dbg, 5);
`else
        req_count = 0;
        for (int i = 0; i < 9; i++) begin
            if (instr_req) req_count++;
            if (i < 8) step(1);
        end
        check_eq("spin_req_count", req_count, 3);
        check_eq("spin_pc", instr_addr, 6);
        check_eq("spin_halted", halted, 0);
`endif

        // Stalled fetch followed by a wrapping backward branch
        reset = 1'b1;
        imem[0] = 8'hC2;
        step(2);
        reset = 1'b0;
        instr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("stall_state", state_dbg, 0);
            check_eq("stall_pc", instr_addr, 0);
        end
        check_eq("stall_r1", dut.gpr[1], 0);
        instr_valid = 1'b1;
        step(3);
        check_eq("br_wrap_pc", instr_addr, 8'hFF);
        check_eq("br_wrap_state", state_dbg, 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
